// File: rtl/interleaver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interleaver_pkg
// Description : Shared definitions for the ping-pong interleaver controller.
//               Holds the default bank geometry, the beats-per-block helper
//               and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package interleaver_pkg;

    // Default interleaver geometry for one bank.
    localparam int ROW_DEFAULT = 512;
    localparam int COL_DEFAULT = 32;

    // Number of input beats that make up one complete bank block.
    function automatic int block_once_need(input int r, input int c);
        return r * c;
    endfunction

    localparam int BLOCK_ONCE_NEED_DEFAULT = ROW_DEFAULT * COL_DEFAULT;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/interleaver_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interleaver_pingpong_ctrl
// Description : Ping-pong sequencer for two external row x col block-
//               interleaver banks. One bank is filled from the upstream
//               stream while the other drains to the downstream stream.
//               All data/valid/ready routing is combinational (no added
//               latency); only the bookkeeping is registered.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   en                     : run enable; falling en stops at the next
//                            input-block boundary
//   s_axis_tdata/tvalid/tready          : upstream 1-bit stream
//   m_axis_tdata/tvalid/tlast/tready    : interleaved downstream stream
//   bk_s_tdata/tvalid/tready [1:0]      : write side of bank k (bit k)
//   bk_m_tdata/tvalid/tlast/tready [1:0]: read side of bank k (bit k)
//   wr_bank / rd_bank      : bank currently written / read
//   bank_full [1:0]        : bank k holds a complete unread block
//   blk_cnt                : output blocks completed since reset (wraps)
// ============================================================================
module interleaver_pingpong_ctrl
    import interleaver_pkg::*;
#(
    parameter int row   = ROW_DEFAULT,
    parameter int col   = COL_DEFAULT,
    parameter int cnt_w = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    // Upstream
    input  logic             s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    // Downstream
    output logic             m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    // Bank write side
    output logic [1:0]       bk_s_tdata,
    output logic [1:0]       bk_s_tvalid,
    input  logic [1:0]       bk_s_tready,
    // Bank read side
    input  logic [1:0]       bk_m_tdata,
    input  logic [1:0]       bk_m_tvalid,
    input  logic [1:0]       bk_m_tlast,
    output logic [1:0]       bk_m_tready,
    // Status
    output logic             wr_bank,
    output logic             rd_bank,
    output logic [1:0]       bank_full,
    output logic [cnt_w-1:0] blk_cnt
);

    localparam int              NEED      = block_once_need(row, col);
    localparam int              IN_W      = $clog2(NEED) + 1;
    localparam logic [IN_W-1:0] LAST_BEAT = IN_W'(NEED - 1);

    ctrl_state_e      state_q,     state_d;
    logic [IN_W-1:0]  in_cnt_q,    in_cnt_d;
    logic             wr_bank_q,   wr_bank_d;
    logic             rd_bank_q,   rd_bank_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic [cnt_w-1:0] blk_cnt_q,   blk_cnt_d;

    logic wr_ok;
    logic in_acc;
    logic in_done;
    logic out_done;
    logic at_boundary;

    // ------------------------------------------------------------------
    // Combinational routing
    // ------------------------------------------------------------------
    // At a block boundary with en low, writing stops immediately (same
    // cycle), so no beat of a new block is ever taken after en falls.
    assign at_boundary = (in_cnt_q == '0);
    assign wr_ok       = (state_q == ST_RUN) && !bank_full_q[wr_bank_q]
                         && !(!en && at_boundary);

    assign bk_s_tdata     = {2{s_axis_tdata}};
    assign bk_s_tvalid[0] = s_axis_tvalid & wr_ok & ~wr_bank_q;
    assign bk_s_tvalid[1] = s_axis_tvalid & wr_ok &  wr_bank_q;
    assign s_axis_tready  = wr_ok & bk_s_tready[wr_bank_q];

    // A bank's output is only exposed once it holds a complete block.
    assign m_axis_tdata   = bk_m_tdata[rd_bank_q];
    assign m_axis_tlast   = bk_m_tlast[rd_bank_q];
    assign m_axis_tvalid  = bk_m_tvalid[rd_bank_q] & bank_full_q[rd_bank_q];
    assign bk_m_tready[0] = m_axis_tready & bank_full_q[0] & ~rd_bank_q;
    assign bk_m_tready[1] = m_axis_tready & bank_full_q[1] &  rd_bank_q;

    assign in_acc   = s_axis_tvalid & s_axis_tready;
    assign in_done  = in_acc & (in_cnt_q == LAST_BEAT);
    assign out_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    assign wr_bank   = wr_bank_q;
    assign rd_bank   = rd_bank_q;
    assign bank_full = bank_full_q;
    assign blk_cnt   = blk_cnt_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en && at_boundary) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (bank_full_q == 2'b00) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Completion and tlast may coincide; they always target different
    // banks (one must be empty to write, the other full to read), so the
    // set and clear below never collide on the same bit.
    always_comb begin
        in_cnt_d    = in_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        blk_cnt_d   = blk_cnt_q;

        if (in_acc) begin
            if (in_done) begin
                in_cnt_d               = '0;
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
            end else begin
                in_cnt_d = in_cnt_q + IN_W'(1);
            end
        end

        if (out_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            blk_cnt_d              = blk_cnt_q + cnt_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interleaver_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_interleaver_pingpong_ctrl
// Description : Directed self-checking bench for the ping-pong controller
//               with row=4, col=2 (8 beats per block). Two behavioural
//               4x2 interleaver banks sit beside the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interleaver_pingpong_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        s_tdata, s_tvalid, s_tready;
    logic        m_tdata, m_tvalid, m_tlast, m_tready;
    logic [1:0]  bk_s_tdata, bk_s_tvalid, bk_s_tready;
    logic [1:0]  bk_m_tdata, bk_m_tvalid, bk_m_tlast, bk_m_tready;
    logic        wr_bank, rd_bank;
    logic [1:0]  bank_full;
    logic [15:0] blk_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    interleaver_pingpong_ctrl #(.row(4), .col(2), .cnt_w(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .bk_s_tdata    (bk_s_tdata),
        .bk_s_tvalid   (bk_s_tvalid),
        .bk_s_tready   (bk_s_tready),
        .bk_m_tdata    (bk_m_tdata),
        .bk_m_tvalid   (bk_m_tvalid),
        .bk_m_tlast    (bk_m_tlast),
        .bk_m_tready   (bk_m_tready),
        .wr_bank       (wr_bank),
        .rd_bank       (rd_bank),
        .bank_full     (bank_full),
        .blk_cnt       (blk_cnt)
    );

    // ------------------------------------------------------------------
    // Behavioural 4x2 banks: written row-major, read column-major.
    // Write index w = r*2 + c; read order r=0..3 within c=0, then c=1.
    // ------------------------------------------------------------------
    logic [7:0] bmem  [0:1];
    logic [2:0] wcnt  [0:1];
    logic [2:0] rcnt  [0:1];
    logic       bfull [0:1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                wcnt[k]  <= 3'd0;
                rcnt[k]  <= 3'd0;
                bfull[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (bk_s_tvalid[k] && bk_s_tready[k]) begin
                    bmem[k][wcnt[k]] <= bk_s_tdata[k];
                    wcnt[k]          <= wcnt[k] + 3'd1;
                    if (wcnt[k] == 3'd7) bfull[k] <= 1'b1;
                end
                if (bk_m_tvalid[k] && bk_m_tready[k]) begin
                    rcnt[k] <= rcnt[k] + 3'd1;
                    if (rcnt[k] == 3'd7) bfull[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            bk_s_tready[k] = ~bfull[k];
            bk_m_tvalid[k] = bfull[k];
            bk_m_tlast[k]  = bfull[k] & (rcnt[k] == 3'd7);
            bk_m_tdata[k]  = bmem[k][{rcnt[k][1:0], rcnt[k][2]}];
        end
    end

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    logic out_bits [$];
    logic out_last [$];
    logic out_bank [$];
    int   acc_cyc  [$];
    int   cyc         = 0;
    int   overlap_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && m_tvalid && m_tready) begin
            out_bits.push_back(m_tdata);
            out_last.push_back(m_tlast);
            out_bank.push_back(rd_bank);
        end
        if (rst_n && s_tvalid && s_tready) acc_cyc.push_back(cyc);
        if (rst_n && bk_s_tvalid[1] && bk_m_tready[0] && bk_m_tvalid[0])
            overlap_cnt <= overlap_cnt + 1;
    end

    // sel: 0 = data bits, 1 = tlast flags, 2 = source bank
    function automatic logic [7:0] blk_field(input int base, input int b, input int sel);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) begin
            int idx;
            idx = base + 8 * b + j;
            if (idx >= out_bits.size()) r[j] = 1'bx;
            else if (sel == 0)          r[j] = out_bits[idx];
            else if (sel == 1)          r[j] = out_last[idx];
            else                        r[j] = out_bank[idx];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one beat starting at a negedge; returns at the negedge after
    // it was accepted (tvalid left high for back-to-back beats).
    task automatic send_beat(input logic d, input string tag);
        bit ok;
        ok = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (s_tready) begin
                @(posedge clk);
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic send_bits(input logic [7:0] pat, input int from, input int to, input string tag);
        for (int i = from; i <= to; i++) send_beat(pat[i], tag);
    endtask

    task automatic wait_blk(input int n, input string tag);
        for (int t = 0; t < 200 && int'(blk_cnt) != n; t++) @(negedge clk);
        check(tag, {16'd0, blk_cnt}, n);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Input patterns (bit i = beat i) and their column-order outputs
    // (output bit j = input bit {0,2,4,6,1,3,5,7}[j]), worked by hand.
    localparam logic [7:0] P0 = 8'h4D, E0 = 8'h2B;
    localparam logic [7:0] P1 = 8'hA5, E1 = 8'hC3;
    localparam logic [7:0] P2 = 8'h3C, E2 = 8'h66;
    localparam logic [7:0] P3 = 8'hE1, E3 = 8'hC9;

    initial begin
        int base;
        int abase;
        int ov0;
        int n;
        int hits;

        // ---------------- 1: reset state, en=0 with valid offered
        do_reset();
        s_tvalid = 1'b1;
        @(negedge clk);
        #1;
        check("rst_s_tready",  {31'd0, s_tready},    0);
        check("rst_m_tvalid",  {31'd0, m_tvalid},    0);
        check("rst_bk_s_tvld", {30'd0, bk_s_tvalid}, 0);
        check("rst_bk_m_trdy", {30'd0, bk_m_tready}, 0);
        check("rst_bank_full", {30'd0, bank_full},   0);
        check("rst_blk_cnt",   {16'd0, blk_cnt},     0);
        check("rst_wr_rd",     {30'd0, wr_bank, rd_bank}, 0);
        @(negedge clk);
        s_tvalid = 1'b0;

        // ---------------- 2: single block
        base = out_bits.size();
        en = 1'b1;
        m_tready = 1'b1;
        send_bits(P0, 0, 7, "t2_accept");
        s_tvalid = 1'b0;
        check("t2_bank_full", {30'd0, bank_full}, 2'b01);
        check("t2_wr_bank",   {31'd0, wr_bank},   1);
        wait_blk(1, "t2_blk_cnt");
        check("t2_data",  {24'd0, blk_field(base, 0, 0)}, E0);
        check("t2_tlast", {24'd0, blk_field(base, 0, 1)}, 8'h80);
        check("t2_bank",  {24'd0, blk_field(base, 0, 2)}, 8'h00);
        check("t2_rd_bank",    {31'd0, rd_bank},   1);
        check("t2_full_after", {30'd0, bank_full}, 0);

        // ---------------- 3: 24 continuous beats, ping-pong overlap
        do_reset();
        base  = out_bits.size();
        abase = acc_cyc.size();
        ov0   = overlap_cnt;
        en = 1'b1;
        m_tready = 1'b1;
        send_bits(P1, 0, 7, "t3_accept");
        send_bits(P2, 0, 7, "t3_accept");
        send_bits(P3, 0, 7, "t3_accept");
        s_tvalid = 1'b0;
        check("t3_no_stall", acc_cyc[abase + 23] - acc_cyc[abase], 23);
        wait_blk(3, "t3_blk_cnt");
        check("t3_data0", {24'd0, blk_field(base, 0, 0)}, E1);
        check("t3_data1", {24'd0, blk_field(base, 1, 0)}, E2);
        check("t3_data2", {24'd0, blk_field(base, 2, 0)}, E3);
        check("t3_banks", {blk_field(base, 2, 2), blk_field(base, 1, 2), blk_field(base, 0, 2)},
              32'h00FF00);
        check("t3_tlast", {blk_field(base, 2, 1), blk_field(base, 1, 1), blk_field(base, 0, 1)},
              32'h808080);
        check("t3_overlap", {31'd0, overlap_cnt > ov0}, 1);

        // ---------------- 4: downstream stalled, both banks fill
        do_reset();
        base  = out_bits.size();
        abase = acc_cyc.size();
        en = 1'b1;
        m_tready = 1'b0;
        send_bits(P0, 0, 7, "t4_accept");
        send_bits(P1, 0, 7, "t4_accept");
        s_tdata  = P2[0];
        s_tvalid = 1'b1;
        hits = 0;
        repeat (5) begin
            #1;
            if (s_tready) hits++;
            @(negedge clk);
        end
        check("t4_stall_rdy",  hits, 0);
        check("t4_accepted",   acc_cyc.size() - abase, 16);
        check("t4_bank_full",  {30'd0, bank_full}, 2'b11);
        check("t4_m_tvalid",   {31'd0, m_tvalid}, 1);
        m_tready = 1'b1;
        n = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            n++;
            #1;
            if (s_tready) break;
        end
        check("t4_resume_lat", n, 8);
        send_bits(P2, 0, 3, "t4_accept");
        s_tvalid = 1'b0;
        wait_blk(2, "t4_blk_cnt");
        check("t4_data0", {24'd0, blk_field(base, 0, 0)}, E0);
        check("t4_data1", {24'd0, blk_field(base, 1, 0)}, E1);
        check("t4_banks", {16'd0, blk_field(base, 1, 2), blk_field(base, 0, 2)}, 32'hFF00);
        check("t4_full_end", {30'd0, bank_full}, 0);

        // ---------------- 5: en falls mid-block
        do_reset();
        base = out_bits.size();
        en = 1'b1;
        m_tready = 1'b1;
        send_bits(P2, 0, 3, "t5_accept_pre");
        en = 1'b0;
        send_bits(P2, 4, 7, "t5_accept_post");
        s_tdata  = 1'b1;
        s_tvalid = 1'b1;
        #1;
        check("t5_boundary_rdy", {31'd0, s_tready}, 0);
        wait_blk(1, "t5_blk_cnt");
        hits = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (s_tready) hits++;
        end
        check("t5_idle_rdy", hits, 0);
        check("t5_data",     {24'd0, blk_field(base, 0, 0)}, E2);
        check("t5_full_end", {30'd0, bank_full}, 0);
        s_tvalid = 1'b0;

        // ---------------- 6: reset pulsed mid-output
        do_reset();
        base = out_bits.size();
        en = 1'b1;
        m_tready = 1'b1;
        send_bits(P0, 0, 7, "t6_accept");
        s_tvalid = 1'b0;
        for (int t = 0; t < 40 && (out_bits.size() - base) < 3; t++) @(negedge clk);
        check("t6_mid_beats", out_bits.size() - base, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_m_tvalid",   {31'd0, m_tvalid},    0);
        check("t6_bank_full",  {30'd0, bank_full},   0);
        check("t6_bk_m_trdy",  {30'd0, bk_m_tready}, 0);
        check("t6_wr_rd",      {30'd0, wr_bank, rd_bank}, 0);
        @(negedge clk);
        #1;
        check("t6_s_tready",   {31'd0, s_tready},    0);
        check("t6_blk_cnt",    {16'd0, blk_cnt},     0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = out_bits.size();
        send_bits(P3, 0, 7, "t6_accept2");
        s_tvalid = 1'b0;
        wait_blk(1, "t6_blk_cnt2");
        check("t6_data",  {24'd0, blk_field(base, 0, 0)}, E3);
        check("t6_tlast", {24'd0, blk_field(base, 0, 1)}, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
